// File: rtl/laser_pool.sv
// laser_pool: multi-slot cannon laser manager.
//   Spawns lasers from the cannon on a fire request at a frame tick,
//   moves them up SPEED pixels per frame, and retires them on top exit
//   or alien hit. Produces a registered per-pixel laser_gfx.
// Ports:
//   clk, reset         pixel clock, synchronous active-high reset
//   hpos, vpos         current pixel column/row
//   vsync              vertical sync; rising edge is the frame tick
//   shoot              fire button
//   cannon_x           cannon left column
//   hit[i]             alien-hit strobe for slot i
//   laser_active[i]    slot i in flight
//   laser_x, laser_y   slot i position at bits [10i+9:10i]
//   laser_gfx          current pixel (one cycle earlier) inside an active laser
//   fired              one-cycle pulse when a laser spawns
module laser_pool #(
  parameter int unsigned NUM_LASERS = 4,
  parameter int unsigned CANNON_Y   = 440,
  parameter int unsigned X_OFFSET   = 7,
  parameter int unsigned LASER_W    = 2,
  parameter int unsigned LASER_H    = 8,
  parameter int unsigned SPEED      = 4,
  parameter int unsigned COOLDOWN   = 8,
  parameter int unsigned AUTO_FIRE  = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [9:0]                 hpos,
  input  logic [9:0]                 vpos,
  input  logic                       vsync,
  input  logic                       shoot,
  input  logic [9:0]                 cannon_x,
  input  logic [NUM_LASERS-1:0]      hit,
  output logic [NUM_LASERS-1:0]      laser_active,
  output logic [10*NUM_LASERS-1:0]   laser_x,
  output logic [10*NUM_LASERS-1:0]   laser_y,
  output logic                       laser_gfx,
  output logic                       fired
);

  localparam int unsigned PW      = 10;
  localparam int unsigned PW1     = PW + 1;
  localparam int unsigned CW      = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int unsigned SPAWN_Y = CANNON_Y - LASER_H;
  localparam int unsigned X_MAX   = 640 - LASER_W;

  logic [NUM_LASERS-1:0]         active_q, active_d;
  logic [NUM_LASERS-1:0][PW-1:0] x_q, x_d;
  logic [NUM_LASERS-1:0][PW-1:0] y_q, y_d;
  logic [CW-1:0]                 cd_q, cd_d;
  logic                          vsync_q, vsync_d;
  logic                          shoot_prev_q, shoot_prev_d;
  logic                          gfx_q, gfx_d;
  logic                          fired_q, fired_d;

  logic                  tick_c;
  logic                  req_c;
  logic                  grant_c;
  logic                  free_found_c;
  logic [NUM_LASERS-1:0] free_sel_c;
  logic [PW1-1:0]        spawn_sum_c;
  logic [PW-1:0]         spawn_x_c;

  // Next-state: hit retire, per-frame motion, fire arbitration, pixel hit test
  always_comb begin
    active_d     = active_q;
    x_d          = x_q;
    y_d          = y_q;
    cd_d         = cd_q;
    vsync_d      = vsync;
    shoot_prev_d = shoot_prev_q;
    gfx_d        = 1'b0;
    fired_d      = 1'b0;
    free_sel_c   = '0;
    free_found_c = 1'b0;

    tick_c = vsync & ~vsync_q;
    req_c  = (AUTO_FIRE != 0) ? shoot : (shoot & ~shoot_prev_q);

    // Lowest-index slot that was free before this edge
    for (int i = 0; i < NUM_LASERS; i++) begin
      if (!active_q[i] && !free_found_c) begin
        free_sel_c[i] = 1'b1;
        free_found_c  = 1'b1;
      end
    end

    grant_c = tick_c & req_c & (cd_q == '0) & free_found_c;

    spawn_sum_c = {1'b0, cannon_x} + PW1'(X_OFFSET);
    spawn_x_c   = (spawn_sum_c > PW1'(X_MAX)) ? PW'(X_MAX) : spawn_sum_c[PW-1:0];

    for (int i = 0; i < NUM_LASERS; i++) begin
      // 11-bit compares so x+W / y+H never wrap
      if (active_q[i] &&
          ({1'b0, hpos} >= {1'b0, x_q[i]}) &&
          ({1'b0, hpos} <  ({1'b0, x_q[i]} + PW1'(LASER_W))) &&
          ({1'b0, vpos} >= {1'b0, y_q[i]}) &&
          ({1'b0, vpos} <  ({1'b0, y_q[i]} + PW1'(LASER_H)))) begin
        gfx_d = 1'b1;
      end

      // A hit wins over motion; position is kept
      if (active_q[i] && hit[i]) begin
        active_d[i] = 1'b0;
      end else if (tick_c && active_q[i]) begin
        if (y_q[i] < PW'(SPEED)) begin
          active_d[i] = 1'b0;
        end else begin
          y_d[i] = y_q[i] - PW'(SPEED);
        end
      end

      // Granted slot was inactive before the edge, so no conflict with the above
      if (grant_c && free_sel_c[i]) begin
        active_d[i] = 1'b1;
        x_d[i]      = spawn_x_c;
        y_d[i]      = PW'(SPAWN_Y);
      end
    end

    if (tick_c) begin
      shoot_prev_d = shoot;
      if (cd_q != '0) begin
        cd_d = cd_q - CW'(1);
      end
    end

    if (grant_c) begin
      cd_d    = CW'(COOLDOWN);
      fired_d = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q     <= '0;
      x_q          <= '0;
      y_q          <= '0;
      cd_q         <= '0;
      vsync_q      <= 1'b0;
      shoot_prev_q <= 1'b0;
      gfx_q        <= 1'b0;
      fired_q      <= 1'b0;
    end else begin
      active_q     <= active_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cd_q         <= cd_d;
      vsync_q      <= vsync_d;
      shoot_prev_q <= shoot_prev_d;
      gfx_q        <= gfx_d;
      fired_q      <= fired_d;
    end
  end

  assign laser_active = active_q;
  assign laser_x      = x_q;
  assign laser_y      = y_q;
  assign laser_gfx    = gfx_q;
  assign fired        = fired_q;

endmodule
